stopwatch_ctrl: RTL

- Mode controller and time-keeping counter that sequences the 4-digit seven-segment display path: produces the MM:SS BCD digits, plus the adjust and select flags the display multiplexer uses for blinking.
- Sits between the button debouncers/tick generators and the BCD-to-segment decoders.
- All timing is driven by single-cycle enable ticks on one clock. There are no derived clocks.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/bcd2_counter.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    localparam int unsigned SEC_MAX_DEF = 59;
    localparam int unsigned MIN_MAX_DEF = 99;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        ADJ   = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] bcd_tens(input int unsigned v);
        return DIGIT_W'(v / 10);
    endfunction

    function automatic logic [DIGIT_W-1:0] bcd_ones(input int unsigned v);
        return DIGIT_W'(v % 10);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps from MAX to 00; wrap flags the increment that wraps.
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = SEC_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] MAX_TENS = bcd_tens(MAX);
    localparam logic [DIGIT_W-1:0] MAX_ONES = bcd_ones(MAX);

    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_ones;
    logic               w_at_max;

    assign w_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
    assign wrap     = inc && w_at_max;
    assign tens     = r_tens;
    assign ones     = r_ones;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (clr || (inc && w_at_max)) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (inc) begin
            if (r_ones == BCD_MAX_DIGIT) begin
                r_ones <= '0;
                r_tens <= r_tens + 1'b1;
            end else begin
                r_ones <= r_ones + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (RUN/PAUSE/ADJ) driving the seconds and minutes BCD counters.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX = MIN_MAX_DEF,
    parameter int unsigned SEC_MAX = SEC_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_adj,
    input  logic               pause_p,
    input  logic               clr_p,
    input  logic               adj_sw,
    input  logic               sel_sw,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               adj_out,
    output logic               sel_out,
    output logic               running
);

    state_t r_state;
    state_t w_next_state;
    logic   r_resume_run;
    logic   r_adj;
    logic   r_running;
    logic   r_sel;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_wrap;
    logic   w_min_wrap_unused;

    // Flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PAUSE;
            r_resume_run <= 1'b0;
            r_adj        <= 1'b0;
            r_running    <= 1'b0;
            r_sel        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_adj     <= (w_next_state == ADJ);
            r_running <= (w_next_state == RUN);
            r_sel     <= sel_sw;
            if (r_state != ADJ && adj_sw) begin
                r_resume_run <= (r_state == RUN);
            end
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RUN:     if (adj_sw) w_next_state = ADJ;
                     else if (pause_p) w_next_state = PAUSE;
            PAUSE:   if (adj_sw) w_next_state = ADJ;
                     else if (pause_p) w_next_state = RUN;
            ADJ:     if (!adj_sw) w_next_state = r_resume_run ? RUN : PAUSE;
            default: w_next_state = PAUSE;
        endcase
    end

    // Increments follow the pre-transition state.
    always_comb begin
        w_sec_inc = 1'b0;
        w_min_inc = 1'b0;
        if (r_state == RUN) begin
            w_sec_inc = tick_1hz;
            w_min_inc = tick_1hz && w_sec_wrap;
        end else if (r_state == ADJ) begin
            w_sec_inc = tick_adj && sel_sw;
            w_min_inc = tick_adj && !sel_sw;
        end
    end

    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_p),
        .inc  (w_sec_inc),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (w_sec_wrap)
    );

    bcd2_counter #(.MAX(MIN_MAX)) u_min (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_p),
        .inc  (w_min_inc),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (w_min_wrap_unused)
    );

    assign adj_out = r_adj;
    assign running = r_running;
    assign sel_out = r_sel;

endmodule
